// File: rtl/axi_crossbar_wr_arbiter_pkg.sv
// Shared crossbar arbiter types: FSM state, QoS width, one-hot helper.
// Imported by the write-path arbiter, its interface and the RR core.
package axi_crossbar_pkg;

  localparam int QOS_WIDTH = 4;
  localparam int OH_MAX    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  function automatic logic [OH_MAX-1:0] idx2oh(
    input int idx
  );
    logic [OH_MAX-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/axi_crossbar_wr_arbiter_if.sv
// Write-scheduler bundle: requests/handshakes in, grant/route/issue out.
// modport master: arbiter side (drives grant/w_sel); slave: crossbar side.
interface axi_crossbar_wr_arbiter_if #(
  parameter int S_COUNT    = 4,
  parameter int M_ISSUE    = 4,
  parameter int CL_S_COUNT = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  parameter int CNT_WIDTH  = $clog2(M_ISSUE + 1)
);
  import axi_crossbar_pkg::*;

  logic [S_COUNT-1:0]           req;
  logic [S_COUNT*QOS_WIDTH-1:0] req_qos;
  logic                         aw_hs;
  logic                         w_last_hs;
  logic                         b_hs;
  logic [S_COUNT-1:0]           grant;
  logic                         grant_valid;
  logic [CL_S_COUNT-1:0]        grant_encoded;
  logic                         w_sel_valid;
  logic [CL_S_COUNT-1:0]        w_sel;
  logic [CNT_WIDTH-1:0]         issue_count;
  logic                         issue_full;
  logic                         b_underflow;

  modport master (
    input  req, req_qos, aw_hs,
    input  w_last_hs, b_hs,
    output grant, grant_valid,
    output grant_encoded,
    output w_sel_valid, w_sel,
    output issue_count, issue_full,
    output b_underflow
  );

  modport slave (
    output req, req_qos, aw_hs,
    output w_last_hs, b_hs,
    input  grant, grant_valid,
    input  grant_encoded,
    input  w_sel_valid, w_sel,
    input  issue_count, issue_full,
    input  b_underflow
  );

endinterface

// File: rtl/axi_crossbar_wr_arbiter_core.sv
// Combinational masked round-robin pick starting at ptr_i, wrapping.
// Ports: req_i, ptr_i, mask_i in; grant_o, grant_enc_o, valid_o out.
module axi_rr_arbiter_core
  import axi_crossbar_pkg::*;
#(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic [N-1:0] mask_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] grant_enc_o,
  output logic         valid_o
);

  logic [N-1:0] elig;
  logic         found;
  logic [W-1:0] enc;

  assign elig = req_i & mask_i;

  always_comb begin
    found = 1'b0;
    enc   = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        enc   = W'(idx);
      end
    end
  end

  assign valid_o     = found;
  assign grant_enc_o = enc;
  assign grant_o     = found ? N'(idx2oh(int'(enc)))
                             : '0;

endmodule

// File: rtl/axi_crossbar_wr_arbiter.sv
// Per-master write scheduler: RR AW grant, W route hold, issue bound.
// clk/rst_n plain; bus on master modport. QoS: AXI_CROSSBAR_WR_ARB_QOS_EN.
module axi_crossbar_wr_arbiter
  import axi_crossbar_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int M_ISSUE    = 4,
  parameter int CL_S_COUNT = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  parameter int CNT_WIDTH  = $clog2(M_ISSUE + 1)
) (
  input  logic clk,
  input  logic rst_n,
  axi_crossbar_wr_arbiter_if.master bus
);

  arb_state_e            state_q, state_d;
  logic [S_COUNT-1:0]    grant_q, grant_d;
  logic [CL_S_COUNT-1:0] enc_q, enc_d;
  logic                  gv_q, gv_d;
  logic [CL_S_COUNT-1:0] wsel_q, wsel_d;
  logic                  wsv_q, wsv_d;
  logic [CL_S_COUNT-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  uf_q, uf_d;

  logic [S_COUNT-1:0]    mask;
  logic [S_COUNT-1:0]    pick_oh;
  logic [CL_S_COUNT-1:0] pick_enc;
  logic                  pick_vld;
  logic                  full;
  logic                  inc;
  logic                  dec;

`ifdef AXI_CROSSBAR_WR_ARB_QOS_EN
  // Only the highest-QoS active requesters stay eligible.
  always_comb begin
    logic [QOS_WIDTH-1:0] maxq;
    maxq = '0;
    mask = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (bus.req[i] &&
          bus.req_qos[i*QOS_WIDTH +: QOS_WIDTH] > maxq)
        maxq = bus.req_qos[i*QOS_WIDTH +: QOS_WIDTH];
    end
    for (int i = 0; i < S_COUNT; i++) begin
      mask[i] =
        bus.req_qos[i*QOS_WIDTH +: QOS_WIDTH] == maxq;
    end
  end
`else
  assign mask = '1;
`endif

  axi_rr_arbiter_core #(
    .N (S_COUNT),
    .W (CL_S_COUNT)
  ) u_core (
    .req_i       (bus.req),
    .ptr_i       (ptr_q),
    .mask_i      (mask),
    .grant_o     (pick_oh),
    .grant_enc_o (pick_enc),
    .valid_o     (pick_vld)
  );

  assign full = cnt_q == CNT_WIDTH'(M_ISSUE);
  assign inc  = bus.aw_hs && state_q == ADDR;
  assign dec  = bus.b_hs;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    enc_d   = enc_q;
    gv_d    = gv_q;
    wsel_d  = wsel_q;
    wsv_d   = wsv_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld && !full) begin
          grant_d = pick_oh;
          enc_d   = pick_enc;
          gv_d    = 1'b1;
          state_d = ADDR;
          if (pick_enc == CL_S_COUNT'(S_COUNT - 1))
            ptr_d = '0;
          else
            ptr_d = pick_enc + CL_S_COUNT'(1);
        end
      end
      ADDR: begin
        if (bus.aw_hs) begin
          grant_d = '0;
          gv_d    = 1'b0;
          wsel_d  = enc_q;
          wsv_d   = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.w_last_hs) begin
          wsel_d  = '0;
          wsv_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous issue and completion cancel out.
  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    unique case (1'b1)
      inc && !dec: cnt_d = cnt_q + CNT_WIDTH'(1);
      dec && !inc: begin
        if (cnt_q == '0) uf_d = 1'b1;
        else cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      enc_q   <= '0;
      gv_q    <= 1'b0;
      wsel_q  <= '0;
      wsv_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      enc_q   <= enc_d;
      gv_q    <= gv_d;
      wsel_q  <= wsel_d;
      wsv_q   <= wsv_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = gv_q;
  assign bus.grant_encoded = enc_q;
  assign bus.w_sel_valid   = wsv_q;
  assign bus.w_sel         = wsel_q;
  assign bus.issue_count   = cnt_q;
  assign bus.issue_full    = full;
  assign bus.b_underflow   = uf_q;

endmodule

// File: tb/tb_axi_crossbar_wr_arbiter.sv
// Directed bench for axi_crossbar_wr_arbiter (S_COUNT=4, M_ISSUE=2).
// QoS steps run only when AXI_CROSSBAR_WR_ARB_QOS_EN is defined.
module tb_axi_crossbar_wr_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  axi_crossbar_wr_arbiter_if #(
    .S_COUNT (4),
    .M_ISSUE (2)
  ) ifc ();

  axi_crossbar_wr_arbiter #(
    .S_COUNT (4),
    .M_ISSUE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  // Enters with grant registered in ADDR; finishes with a B.
  task automatic burst(
    input string      tag,
    input logic [3:0] g,
    input logic [1:0] e
  );
    chk({tag, " grant"}, 32'(ifc.grant), 32'(g));
    chk({tag, " gv"}, 32'(ifc.grant_valid), 1);
    ifc.aw_hs = 1'b1;
    step();
    ifc.aw_hs = 1'b0;
    chk({tag, " wsv"}, 32'(ifc.w_sel_valid), 1);
    chk({tag, " wsel"}, 32'(ifc.w_sel), 32'(e));
    chk({tag, " cnt1"}, 32'(ifc.issue_count), 1);
    ifc.w_last_hs = 1'b1;
    ifc.b_hs      = 1'b1;
    step();
    ifc.w_last_hs = 1'b0;
    ifc.b_hs      = 1'b0;
    chk({tag, " wsv0"}, 32'(ifc.w_sel_valid), 0);
    chk({tag, " cnt0"}, 32'(ifc.issue_count), 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ifc.req       = 4'b1111;
    ifc.req_qos   = '0;
    ifc.aw_hs     = 1'b0;
    ifc.w_last_hs = 1'b0;
    ifc.b_hs      = 1'b0;
    step();
    step();
    chk("rst grant", 32'(ifc.grant), 0);
    chk("rst gv", 32'(ifc.grant_valid), 0);
    chk("rst wsv", 32'(ifc.w_sel_valid), 0);
    chk("rst cnt", 32'(ifc.issue_count), 0);
    chk("rst uf", 32'(ifc.b_underflow), 0);

    // 1: round robin across all four
    rst_n = 1'b1;
    step();
    burst("rr0", 4'b0001, 2'd0);
    step();
    burst("rr1", 4'b0010, 2'd1);
    step();
    burst("rr2", 4'b0100, 2'd2);
    step();
    burst("rr3", 4'b1000, 2'd3);
    step();
    ifc.req = 4'b0000;
    burst("rr4", 4'b0001, 2'd0);

    // 2: grant and route held after req drops
    ifc.req = 4'b0100;
    step();
    ifc.req = 4'b0000;
    step();
    chk("hold grant", 32'(ifc.grant), 32'h4);
    chk("hold gv", 32'(ifc.grant_valid), 1);
    ifc.aw_hs = 1'b1;
    step();
    ifc.aw_hs = 1'b0;
    step();
    chk("hold wsel", 32'(ifc.w_sel), 2);
    chk("hold wsv", 32'(ifc.w_sel_valid), 1);
    chk("hold gv0", 32'(ifc.grant_valid), 0);
    ifc.w_last_hs = 1'b1;
    step();
    ifc.w_last_hs = 1'b0;
    chk("end wsv", 32'(ifc.w_sel_valid), 0);
    chk("end wsel", 32'(ifc.w_sel), 0);
    chk("end cnt", 32'(ifc.issue_count), 1);

    // 3: issue limit blocks, B frees a slot
    ifc.req = 4'b0001;
    step();
    chk("b2 grant", 32'(ifc.grant), 1);
    ifc.aw_hs = 1'b1;
    step();
    ifc.aw_hs = 1'b0;
    ifc.w_last_hs = 1'b1;
    step();
    ifc.w_last_hs = 1'b0;
    chk("full", 32'(ifc.issue_full), 1);
    chk("full cnt", 32'(ifc.issue_count), 2);
    step();
    step();
    chk("full gv", 32'(ifc.grant_valid), 0);
    chk("full grant", 32'(ifc.grant), 0);
    ifc.b_hs = 1'b1;
    step();
    ifc.b_hs = 1'b0;
    chk("free cnt", 32'(ifc.issue_count), 1);
    chk("free full", 32'(ifc.issue_full), 0);
    chk("free gv0", 32'(ifc.grant_valid), 0);
    step();
    chk("free gv", 32'(ifc.grant_valid), 1);
    chk("free grant", 32'(ifc.grant), 1);
    ifc.req = 4'b0000;
    ifc.aw_hs = 1'b1;
    step();
    ifc.aw_hs = 1'b0;
    ifc.w_last_hs = 1'b1;
    ifc.b_hs = 1'b1;
    step();
    ifc.w_last_hs = 1'b0;
    ifc.b_hs = 1'b0;
    chk("drain cnt", 32'(ifc.issue_count), 1);

    // 4: simultaneous aw/b, then underflow
    ifc.req = 4'b0010;
    step();
    chk("sim grant", 32'(ifc.grant), 2);
    ifc.req = 4'b0000;
    ifc.aw_hs = 1'b1;
    ifc.b_hs = 1'b1;
    step();
    ifc.aw_hs = 1'b0;
    ifc.b_hs = 1'b0;
    chk("sim cnt", 32'(ifc.issue_count), 1);
    ifc.w_last_hs = 1'b1;
    ifc.b_hs = 1'b1;
    step();
    ifc.w_last_hs = 1'b0;
    chk("b cnt0", 32'(ifc.issue_count), 0);
    chk("b uf0", 32'(ifc.b_underflow), 0);
    step();
    ifc.b_hs = 1'b0;
    chk("uf", 32'(ifc.b_underflow), 1);
    chk("uf cnt", 32'(ifc.issue_count), 0);
    step();
    chk("uf sticky", 32'(ifc.b_underflow), 1);

    // 5: async reset mid-burst
    ifc.req = 4'b1000;
    step();
    chk("r5 grant", 32'(ifc.grant), 32'h8);
    ifc.aw_hs = 1'b1;
    step();
    ifc.aw_hs = 1'b0;
    chk("r5 wsel", 32'(ifc.w_sel), 3);
    rst_n = 1'b0;
    #1;
    chk("r5 wsv", 32'(ifc.w_sel_valid), 0);
    chk("r5 gv", 32'(ifc.grant_valid), 0);
    chk("r5 cnt", 32'(ifc.issue_count), 0);
    chk("r5 uf", 32'(ifc.b_underflow), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("r5 regrant", 32'(ifc.grant), 32'h8);
    chk("r5 enc", 32'(ifc.grant_encoded), 3);
    ifc.req = 4'b0000;
    burst("r5b", 4'b1000, 2'd3);

`ifdef AXI_CROSSBAR_WR_ARB_QOS_EN
    // 6: QoS filter, then equal QoS falls back to RR
    ifc.req     = 4'b0011;
    ifc.req_qos = 16'h0092;
    step();
    ifc.req = 4'b0000;
    burst("qos hi", 4'b0010, 2'd1);
    ifc.req     = 4'b0011;
    ifc.req_qos = 16'h0055;
    step();
    ifc.req = 4'b0000;
    burst("qos eq", 4'b0001, 2'd0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
